line_buffer_3x3: RTL
====================

# line_buffer_3x3

Sliding-window generator that feeds the 3x3 convolution stage. It accepts a raster-order stream of signed 8-bit pixels, one per valid cycle, and stores the two previous image rows in internal line buffers. For every pixel that completes a full 3x3 neighbourhood, it emits that neighbourhood as nine parallel signed 8-bit values with a valid strobe. The nine outputs map one-to-one onto the convolution stage's data inputs 0..8.

## Interface
- IMG_W, default 28: image width in pixels; must be ≥3.
- IMG_H, default 28: image height in pixels; must be ≥3.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- valid_in  input  1  data_in carries the next raster pixel this cycle.
- data_in  input  8 signed  pixel value.
- data_out0..data_out8  output  8 signed each  window pixels, row-major: 0 = (r-2,c-2), 1 = (r-2,c-1), 2 = (r-2,c), 3 = (r-1,c-2) … 8 = (r,c).
- valid_out  output  1  data_out0..8 hold a complete window this cycle.
- frame_done  output  1  present only with WINDOW_FRAME_DONE_EN; see Configuration.

## Operation
- Counters:
  - col runs 0..IMG_W-1 and advances only on valid_in.
  - row runs 0..IMG_H-1 and advances when col wraps.
  - After pixel (IMG_H-1, IMG_W-1), both counters return to 0, which starts the next frame. There is no frame-start input.
- Line buffers:
  - There are two IMG_W-deep buffers, lb1 (row r-1) and lb2 (row r-2), indexed by col.
  - On valid_in: read lb1[col] and lb2[col], then write lb2[col] ← lb1[col] and lb1[col] ← data_in.
  - No reset is required on buffer contents.
- Window registers:
  - The window is a 3x3 register array.
  - On valid_in, each row shifts left by one column.
  - The new right column is {lb2[col], lb1[col], data_in}, top to bottom.
- Output gating:
  - A window is emitted when valid_in is high with row ≥ 2 and col ≥ 2.
  - Windows spanning a row wrap (col < 2) or using stale prior-frame rows (row < 2) are never emitted.
- Window count: exactly (IMG_H-2)·(IMG_W-2) windows per frame.
- Arithmetic: none. Values pass through bit-exact, sign preserved.
- No backpressure. Gaps in valid_in of any length are allowed, and all state holds during gaps.

## Timing
- Reset: every output is 0. col, row and the window registers are 0.
- Reset mid-frame: counters return to 0, and the next accepted pixel is treated as (0,0) of a new frame. valid_out and frame_done drop to 0 asynchronously.
- Latency: valid_out and data_out0..8 are registered. The window completed by the pixel accepted at edge N is visible after edge N+1.
- valid_out is high for exactly one cycle per emitted window. Back-to-back windows occur on consecutive cycles under continuous input.
- data_out0..8 hold their last value while valid_out is low.
- Boundary conditions:
  - Row wrap: at col = IMG_W-1 the counter rolls to 0 on the same edge that accepts the pixel.
  - Frame wrap: at the last pixel, both counters roll on the same edge.
- Read-before-write: the read and the write to the same lb index in one cycle return the old (pre-write) contents.

## Configuration
- Macro: WINDOW_FRAME_DONE_EN.
- Defined:
  - Output port frame_done exists and resets to 0.
  - It pulses high for one cycle, coincident with the valid_out of the final window of a frame (pixel IMG_H-1, IMG_W-1).
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use IMG_W=5, IMG_H=4 and pixel value = row·5 + col, unless stated otherwise.

- Reset then idle: hold rst_n low 3 cycles, then keep valid_in=0 for 10 cycles. All outputs stay 0.
- One continuous frame of 20 pixels:
  - Exactly 6 valid_out pulses.
  - First window = 0,1,2,5,6,7,10,11,12; it appears 1 cycle after pixel 12 is accepted.
  - Last window = 7,8,9,12,13,14,17,18,19.
- Random valid_in gaps, 0–4 idle cycles between pixels: same 6 windows in the same order. Outputs are stable during gaps.
- Two back-to-back frames, with the second frame's values +50:
  - The second frame yields 6 windows.
  - Its first window is 50,51,52,55,56,57,60,61,62, with no window mixing frames.
  - With WINDOW_FRAME_DONE_EN, frame_done pulses exactly twice, each time with the last window.
- Signed extremes: frame filled with -128 except pixel 12 = 127. The first window shows 127 in data_out8 and -128 in the other eight outputs, sign intact.
- Reset mid-frame: assert rst_n after 9 pixels, then send a full 20-pixel frame. Exactly 6 windows appear, and the first window equals 0,1,2,5,6,7,10,11,12.

Source files
------------

// File: rtl/line_buffer_3x3.sv
// rtl/line_buffer_3x3.sv - 3x3 sliding-window generator over a raster pixel stream
// Optional frame_done pulse on the last window of a frame: define WINDOW_FRAME_DONE_EN.
module line_buffer_3x3 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic signed [7:0] data_in,
  output logic signed [7:0] data_out0,
  output logic signed [7:0] data_out1,
  output logic signed [7:0] data_out2,
  output logic signed [7:0] data_out3,
  output logic signed [7:0] data_out4,
  output logic signed [7:0] data_out5,
  output logic signed [7:0] data_out6,
  output logic signed [7:0] data_out7,
  output logic signed [7:0] data_out8,
  output logic              valid_out
`ifdef WINDOW_FRAME_DONE_EN
  ,
  output logic              frame_done
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic signed [7:0] lb1_mem [IMG_W];
  logic signed [7:0] lb2_mem [IMG_W];
  logic signed [7:0] lb1_rd, lb2_rd;

  logic signed [7:0] win_q  [9];
  logic signed [7:0] win_d  [9];
  logic signed [7:0] dout_q [9];
  logic signed [7:0] dout_d [9];

  logic emit_q, emit_d;
  logic valid_out_q, valid_out_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Combinational reads happen before the clocked write, so same-index accesses see old data.
  assign lb1_rd = lb1_mem[col_q];
  assign lb2_rd = lb2_mem[col_q];

  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1_mem[col_q] <= data_in;
      lb2_mem[col_q] <= lb1_rd;
    end
  end

  always_comb begin
    win_d = win_q;
    if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r+1];
        win_d[3*r + 1] = win_q[3*r+2];
      end
      win_d[2] = lb2_rd;
      win_d[5] = lb1_rd;
      win_d[8] = data_in;
    end
  end

  assign emit_d      = valid_in && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign valid_out_d = emit_q;

  always_comb begin
    dout_d = dout_q;
    if (emit_q) dout_d = win_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      emit_q      <= 1'b0;
      valid_out_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      emit_q      <= emit_d;
      valid_out_q <= valid_out_d;
      win_q       <= win_d;
      dout_q      <= dout_d;
    end
  end

`ifdef WINDOW_FRAME_DONE_EN
  logic last_q, last_d;
  logic frame_done_q, frame_done_d;

  assign last_d       = emit_d && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign frame_done_d = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
`endif

  assign data_out0 = dout_q[0];
  assign data_out1 = dout_q[1];
  assign data_out2 = dout_q[2];
  assign data_out3 = dout_q[3];
  assign data_out4 = dout_q[4];
  assign data_out5 = dout_q[5];
  assign data_out6 = dout_q[6];
  assign data_out7 = dout_q[7];
  assign data_out8 = dout_q[8];
  assign valid_out = valid_out_q;

endmodule
